// File: rtl/ultrasonic_meas_ctrl.sv
// HC-SR04-class ultrasonic measurement sequencer: trigger, echo timing with timeout, hold-off, near flag.
// Optional: define ULTRA_NEAR_HYST_EN to require 3 agreeing samples before near changes.
module ultrasonic_meas_ctrl #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned NEAR_THRESH    = 58000,
    parameter int unsigned CW             = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          echo,
    output logic          trig,
    output logic          busy,
    output logic          sample_valid,
    output logic [CW-1:0] echo_cycles,
    output logic          timeout,
    output logic          near
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    localparam int unsigned PH_MAX_I = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] HO_LAST   = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PH_MAX    = CW'(PH_MAX_I);
    localparam logic [CW-1:0] NEAR_TH   = CW'(NEAR_THRESH);

    state_t        state_q;
    logic          echo_m_q;
    logic          echo_s_q;
    logic          echo_d_q;
    logic [CW-1:0] ph_q;
    logic [CW-1:0] tcnt_q;
    logic [CW-1:0] width_q;

    logic [CW-1:0] ph_d;
    logic [CW-1:0] tcnt_d;
    logic [CW-1:0] width_d;
    logic          tcnt_hit;
    logic          echo_rise;
    logic          echo_fall;
    logic          near_qual;

    // Saturating increments; counters never wrap.
    always_comb begin
        ph_d      = (ph_q >= PH_MAX) ? PH_MAX : ph_q + CW'(1);
        tcnt_d    = (tcnt_q >= TO_MAX) ? TO_MAX : tcnt_q + CW'(1);
        width_d   = (width_q >= TO_MAX) ? TO_MAX : width_q + CW'(1);
        tcnt_hit  = (tcnt_d >= TO_MAX);
        echo_rise = echo_s_q & ~echo_d_q;
        echo_fall = ~echo_s_q & echo_d_q;
        near_qual = ~timeout & (echo_cycles < NEAR_TH);
    end

`ifdef ULTRA_NEAR_HYST_EN
    logic [1:0] run_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            echo_m_q     <= 1'b0;
            echo_s_q     <= 1'b0;
            echo_d_q     <= 1'b0;
            ph_q         <= '0;
            tcnt_q       <= '0;
            width_q      <= '0;
            trig         <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            echo_cycles  <= '0;
            timeout      <= 1'b0;
            near         <= 1'b0;
`ifdef ULTRA_NEAR_HYST_EN
            run_q        <= 2'd0;
`endif
        end else begin
            echo_m_q     <= echo;
            echo_s_q     <= echo_m_q;
            echo_d_q     <= echo_s_q;
            sample_valid <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start || continuous) begin
                        state_q <= S_TRIG;
                        trig    <= 1'b1;
                        busy    <= 1'b1;
                        ph_q    <= '0;
                    end
                end
                S_TRIG: begin
                    if (ph_q >= TRIG_LAST) begin
                        state_q <= S_WAIT_ECHO;
                        trig    <= 1'b0;
                        tcnt_q  <= '0;
                    end else begin
                        ph_q <= ph_d;
                    end
                end
                S_WAIT_ECHO: begin
                    tcnt_q <= tcnt_d;
                    if (tcnt_hit) begin
                        state_q      <= S_HOLDOFF;
                        ph_q         <= '0;
                        sample_valid <= 1'b1;
                        timeout      <= 1'b1;
                        echo_cycles  <= '0;
                    end else if (echo_rise) begin
                        state_q <= S_MEASURE;
                        width_q <= '0;
                    end
                end
                S_MEASURE: begin
                    // On the fall cycle echo_d is still high, so it contributes the final count.
                    if (echo_fall) begin
                        state_q      <= S_HOLDOFF;
                        ph_q         <= '0;
                        sample_valid <= 1'b1;
                        timeout      <= 1'b0;
                        echo_cycles  <= width_d;
                    end else if (echo_s_q) begin
                        tcnt_q  <= tcnt_d;
                        width_q <= width_d;
                        if (tcnt_hit) begin
                            state_q      <= S_HOLDOFF;
                            ph_q         <= '0;
                            sample_valid <= 1'b1;
                            timeout      <= 1'b1;
                            echo_cycles  <= width_d;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (ph_q >= HO_LAST) begin
                        ph_q <= '0;
                        if (continuous) begin
                            state_q <= S_TRIG;
                            trig    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        ph_q <= ph_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    trig    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase

            // Presence flag follows the published sample one cycle after its strobe.
            if (sample_valid) begin
`ifdef ULTRA_NEAR_HYST_EN
                if (near_qual == near) begin
                    run_q <= 2'd0;
                end else if (run_q == 2'd2) begin
                    near  <= near_qual;
                    run_q <= 2'd0;
                end else begin
                    run_q <= run_q + 2'd1;
                end
`else
                near <= near_qual;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_meas_ctrl.sv
// Directed self-checking bench for ultrasonic_meas_ctrl (small timing parameters).
module tb_ultrasonic_meas_ctrl;

    localparam int unsigned TRIG = 10;
    localparam int unsigned TO   = 200;
    localparam int unsigned HO   = 50;
    localparam int unsigned NT   = 100;
    localparam int unsigned CW   = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          echo;
    logic          trig;
    logic          busy;
    logic          sample_valid;
    logic [CW-1:0] echo_cycles;
    logic          timeout;
    logic          near;

    int checks   = 0;
    int passed   = 0;
    int sv_count = 0;
    int cyc      = 0;

`ifdef ULTRA_NEAR_HYST_EN
    localparam int NS = 5;
    int   near_w[NS] = '{60, 150, 60, 60, 60};
    logic near_e[NS] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    localparam int NS = 4;
    int   near_w[NS] = '{60, 150, 60, 0};
    logic near_e[NS] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

    ultrasonic_meas_ctrl #(
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TO),
        .HOLDOFF_CYCLES(HO),
        .NEAR_THRESH   (NT),
        .CW            (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .echo        (echo),
        .trig        (trig),
        .busy        (busy),
        .sample_valid(sample_valid),
        .echo_cycles (echo_cycles),
        .timeout     (timeout),
        .near        (near)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sample_valid === 1'b1) sv_count <= sv_count + 1;

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_trig_high;
        int g;
        g = 0;
        while (trig !== 1'b1 && g < 4000) begin @(negedge clk); g++; end
    endtask

    task automatic wait_trig_pulse(output int hi);
        hi = 0;
        wait_trig_high();
        while (trig === 1'b1 && hi < 4000) begin @(negedge clk); hi++; end
    endtask

    // n cycles after trig is seen low, raise echo for w cycles (w<0: leave high, w==0: no echo)
    task automatic drive_echo(input int n, input int w);
        if (w != 0) begin
            repeat (n) @(negedge clk);
            echo = 1'b1;
            if (w > 0) begin
                repeat (w) @(negedge clk);
                echo = 1'b0;
            end
        end
    endtask

    task automatic wait_valid;
        int g;
        g = 0;
        while (sample_valid !== 1'b1 && g < 4000) begin @(negedge clk); g++; end
    endtask

    task automatic wait_idle;
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 4000) begin @(negedge clk); g++; end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (trig !== 1'b0) $display("FAIL reset_trig: got %0b want 0", trig); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
        checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", sample_valid); else passed++;
        checks++; if (echo_cycles !== 32'd0) $display("FAIL reset_echo_cycles: got %0d want 0", echo_cycles); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", timeout); else passed++;
        checks++; if (near !== 1'b0) $display("FAIL reset_near: got %0b want 0", near); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_shot;
        int hi, t0, t1, sv0;
        sv0 = sv_count;
        pulse_start();
        checks++; if (trig !== 1'b1) $display("FAIL single_trig_rise: got %0b want 1", trig); else passed++;
        wait_trig_pulse(hi);
        checks++; if (hi != 10) $display("FAIL single_trig_width: got %0d want 10", hi); else passed++;
        t0 = cyc;
        drive_echo(20, 60);
        wait_valid();
        t1 = cyc;
        checks++; if (sample_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", sample_valid); else passed++;
        checks++; if (echo_cycles !== 32'd60) $display("FAIL single_echo_cycles: got %0d want 60", echo_cycles); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL single_timeout: got %0b want 0", timeout); else passed++;
        // fall is seen 3 cycles after the raw echo drops (2 sync flops + edge detect)
        checks++; if (t1 - t0 != 83) $display("FAIL single_latency: got %0d want 83", t1 - t0); else passed++;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) $display("FAIL single_valid_one_cycle: got %0b want 0", sample_valid); else passed++;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_idle();
        checks++; if (cyc - t1 != 50) $display("FAIL single_holdoff: got %0d want 50", cyc - t1); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || trig !== 1'b0) $display("FAIL single_start_dropped: got busy=%0b trig=%0b want 0 0", busy, trig); else passed++;
        checks++; if (sv_count - sv0 != 1) $display("FAIL single_valid_count: got %0d want 1", sv_count - sv0); else passed++;
    endtask

    task automatic test_no_echo;
        int hi, t0;
        pulse_start();
        wait_trig_pulse(hi);
        t0 = cyc;
        wait_valid();
        checks++; if (sample_valid !== 1'b1) $display("FAIL noecho_valid: got %0b want 1", sample_valid); else passed++;
        checks++; if (cyc - t0 != 200) $display("FAIL noecho_latency: got %0d want 200", cyc - t0); else passed++;
        checks++; if (timeout !== 1'b1) $display("FAIL noecho_timeout: got %0b want 1", timeout); else passed++;
        checks++; if (echo_cycles !== 32'd0) $display("FAIL noecho_echo_cycles: got %0d want 0", echo_cycles); else passed++;
        wait_idle();
    endtask

    task automatic test_far;
        int hi;
        pulse_start();
        wait_trig_pulse(hi);
        drive_echo(20, 150);
        wait_valid();
        checks++; if (sample_valid !== 1'b1) $display("FAIL far_valid: got %0b want 1", sample_valid); else passed++;
        checks++; if (echo_cycles !== 32'd150) $display("FAIL far_echo_cycles: got %0d want 150", echo_cycles); else passed++;
        checks++; if (timeout !== 1'b0) $display("FAIL far_timeout: got %0b want 0", timeout); else passed++;
        wait_idle();
    endtask

    task automatic test_stuck_echo;
        int hi, t0;
        echo = 1'b1;
        repeat (4) @(negedge clk);
        pulse_start();
        wait_trig_pulse(hi);
        t0 = cyc;
        wait_valid();
        checks++; if (cyc - t0 != 200) $display("FAIL stuck_latency: got %0d want 200", cyc - t0); else passed++;
        checks++; if (timeout !== 1'b1) $display("FAIL stuck_timeout: got %0b want 1", timeout); else passed++;
        checks++; if (echo_cycles !== 32'd0) $display("FAIL stuck_echo_cycles: got %0d want 0", echo_cycles); else passed++;
        echo = 1'b0;
        wait_idle();
        // rise accepted at timeout count 23; the remaining 177 cycles are counted before timeout
        pulse_start();
        wait_trig_pulse(hi);
        t0 = cyc;
        drive_echo(20, -1);
        wait_valid();
        checks++; if (cyc - t0 != 200) $display("FAIL stuckrise_latency: got %0d want 200", cyc - t0); else passed++;
        checks++; if (timeout !== 1'b1) $display("FAIL stuckrise_timeout: got %0b want 1", timeout); else passed++;
        checks++; if (echo_cycles !== 32'd177) $display("FAIL stuckrise_echo_cycles: got %0d want 177", echo_cycles); else passed++;
        echo = 1'b0;
        wait_idle();
    endtask

    task automatic test_continuous;
        int hi, sv0;
        int r[4];
        continuous = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_trig_high();
            r[i] = cyc;
            wait_trig_pulse(hi);
            drive_echo(20, 60);
            wait_valid();
            checks++; if (echo_cycles !== 32'd60) $display("FAIL cont_echo_cycles[%0d]: got %0d want 60", i, echo_cycles); else passed++;
            @(negedge clk);
        end
        wait_trig_high();
        r[3] = cyc;
        // 10 trig + (20+2) to echo_s rise + 60 width + 50 holdoff + 1 edge detect
        for (int i = 0; i < 3; i++) begin
            checks++; if (r[i+1] - r[i] != 143) $display("FAIL cont_period[%0d]: got %0d want 143", i, r[i+1] - r[i]); else passed++;
        end
        repeat (3) @(negedge clk);
        checks++; if (trig !== 1'b1) $display("FAIL cont_mid_pulse: got %0b want 1", trig); else passed++;
        sv0 = sv_count;
        rst = 1'b1;
        continuous = 1'b0;
        @(negedge clk);
        checks++; if (trig !== 1'b0) $display("FAIL rst_trig: got %0b want 0", trig); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else passed++;
        checks++; if (echo_cycles !== 32'd0) $display("FAIL rst_echo_cycles: got %0d want 0", echo_cycles); else passed++;
        checks++; if (near !== 1'b0 || timeout !== 1'b0) $display("FAIL rst_flags: got near=%0b timeout=%0b want 0 0", near, timeout); else passed++;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (sv_count != sv0) $display("FAIL rst_no_valid: got %0d want %0d", sv_count, sv0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_stays_idle: got %0b want 0", busy); else passed++;
    endtask

    task automatic test_near;
        int hi;
        for (int i = 0; i < NS; i++) begin
            pulse_start();
            wait_trig_pulse(hi);
            drive_echo(20, near_w[i]);
            wait_valid();
            @(negedge clk);
            checks++; if (near !== near_e[i]) $display("FAIL near[%0d]: got %0b want %0b", i, near, near_e[i]); else passed++;
            wait_idle();
            checks++; if (near !== near_e[i]) $display("FAIL near_hold[%0d]: got %0b want %0b", i, near, near_e[i]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_no_echo();
        test_far();
        test_stuck_echo();
        test_continuous();
        test_near();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
